// File: rtl/fetch_if.sv
// Handshake and bus signals between the fetch stage, its controller and the instruction memory.
// The slave side is the fetch unit and the master side is the surrounding pipeline.
interface fetch_if;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic [15:0] imem_instr;
    logic [7:0]  imem_addr;
    logic [15:0] ir;
    logic [7:0]  ir_pc;
    logic        ir_valid;
    logic        halted;
    logic        misalign;
    logic [15:0] fetch_count;

    modport slave (
        input  start, stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        output imem_addr, ir, ir_pc, ir_valid, halted, misalign, fetch_count
    );

    modport master (
        output start, stall, branch_taken, branch_target, jump, jump_target, imem_instr,
        input  imem_addr, ir, ir_pc, ir_valid, halted, misalign, fetch_count
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, latches memory words into the IR, and handles
// stall, jump/branch redirect with flush, HALT detection and a saturating fetch counter.
module fetch_unit #(
    parameter logic [7:0]  RESET_PC    = 8'h00,
    parameter logic [3:0]  HALT_OPCODE = 4'hF,
    parameter logic [15:0] NOP_WORD    = 16'h0000
) (
    input  logic   clk,
    input  logic   rst_n,
    fetch_if.slave bus
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [15:0] ir_q, ir_d;
    logic [7:0]  irPc_q, irPc_d;
    logic        irValid_q, irValid_d;
    logic        halted_q, halted_d;
    logic        misalign_q, misalign_d;
    logic [15:0] fetchCount_q, fetchCount_d;

    logic        redirect;
    logic [7:0]  redirectTarget;
    logic [15:0] countInc;

    // Jump outranks branch when both request a redirect in the same cycle.
    assign redirect       = bus.jump | bus.branch_taken;
    assign redirectTarget = bus.jump ? bus.jump_target : bus.branch_target;
    assign countInc       = (fetchCount_q == 16'hFFFF) ? fetchCount_q : fetchCount_q + 16'd1;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        ir_d         = ir_q;
        irPc_d       = irPc_q;
        irValid_d    = irValid_q;
        misalign_d   = misalign_q;
        fetchCount_d = fetchCount_q;

        case (state_q)
            IDLE: begin
                irValid_d = 1'b0;
                if (bus.start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (redirect) begin
                    pc_d       = {redirectTarget[7:1], 1'b0};
                    misalign_d = redirectTarget[0];
                    ir_d       = NOP_WORD;
                    irValid_d  = 1'b0;
                end else if (!bus.stall) begin
                    ir_d         = bus.imem_instr;
                    irPc_d       = pc_q;
                    irValid_d    = 1'b1;
                    fetchCount_d = countInc;
                    // The PC stays on the HALT word so a resume continues right after it.
                    if (bus.imem_instr[15:12] == HALT_OPCODE) begin
                        state_d = HALT;
                    end else begin
                        pc_d = pc_q + 8'd2;
                    end
                end
            end
            HALT: begin
                irValid_d = 1'b0;
                if (bus.start) begin
                    pc_d    = pc_q + 8'd2;
                    state_d = RUN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pc_q         <= RESET_PC;
            ir_q         <= NOP_WORD;
            irPc_q       <= 8'h00;
            irValid_q    <= 1'b0;
            halted_q     <= 1'b0;
            misalign_q   <= 1'b0;
            fetchCount_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            ir_q         <= ir_d;
            irPc_q       <= irPc_d;
            irValid_q    <= irValid_d;
            halted_q     <= halted_d;
            misalign_q   <= misalign_d;
            fetchCount_q <= fetchCount_d;
        end
    end

    assign bus.imem_addr   = pc_q;
    assign bus.ir          = ir_q;
    assign bus.ir_pc       = irPc_q;
    assign bus.ir_valid    = irValid_q;
    assign bus.halted      = halted_q;
    assign bus.misalign    = misalign_q;
    assign bus.fetch_count = fetchCount_q;

endmodule
